// File: rtl/intra_sched_pkg.sv
// intra_sched_pkg: shared state encoding, mode/preStage constants and prefetch-count helper
package intra_sched_pkg;

    typedef enum logic [1:0] {S_IDLE, S_PRE, S_MAIN} state_t;

    localparam logic [2:0] MIN_TU_LOG2 = 3'd2;
    localparam logic [2:0] MAX_TU_LOG2 = 3'd5;
    localparam logic [5:0] DC_MODE     = 6'd1;
    localparam logic [3:0] PRE_MAIN    = 4'd8;
    localparam logic [3:0] PRE_IDLE    = 4'd15;

    // Number of prefetch stages ahead of the main scan; DC needs none.
    function automatic logic [2:0] pre_count(input logic [2:0] size, input logic [5:0] m);
        return (m == DC_MODE) ? 3'd0 :
               (size == 3'd3 || size == 3'd4) ? 3'd1 :
               (size == 3'd5) ? 3'd4 : 3'd0;
    endfunction

endpackage

// File: rtl/intra_stage_sched_if.sv
// intra_stage_sched_if: TU command handshake and stage outputs of the scheduler
interface intra_stage_sched_if;
    logic       tu_valid;
    logic       tu_ready;
    logic [2:0] tu_size;
    logic [5:0] tu_mode;
    logic       stage_valid;
    logic [3:0] preStage;
    logic [2:0] X;
    logic [2:0] Y;
    logic [2:0] tuSize;
    logic [5:0] mode;
    logic       tu_done;
    logic       cfg_err;

    modport master (
        output tu_valid, tu_size, tu_mode,
        input  tu_ready, stage_valid, preStage, X, Y, tuSize, mode, tu_done, cfg_err
    );

    modport slave (
        input  tu_valid, tu_size, tu_mode,
        output tu_ready, stage_valid, preStage, X, Y, tuSize, mode, tu_done, cfg_err
    );
endinterface

// File: rtl/intra_blk_scan.sv
// intra_blk_scan: X-fastest block scan counter over an N x N grid, N = 1 << n_log
module intra_blk_scan (
    input  logic       clk,
    input  logic       arst,
    input  logic       clr,
    input  logic       en,
    input  logic [1:0] n_log,
    output logic [2:0] x,
    output logic [2:0] y,
    output logic       last
);
    logic [2:0] x_q, y_q, nm1;

    // Grid bound and final-position flag
    always_comb begin
        nm1  = 3'((4'd1 << n_log) - 4'd1);
        last = (x_q == nm1) && (y_q == nm1);
        x    = x_q;
        y    = y_q;
    end

    // Advance X, carry into Y, wrap both to zero after the final block
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            x_q <= '0;
            y_q <= '0;
        end else if (clr) begin
            x_q <= '0;
            y_q <= '0;
        end else if (en) begin
            x_q <= (x_q == nm1) ? 3'd0 : x_q + 3'd1;
            y_q <= (x_q != nm1) ? y_q : (y_q == nm1) ? 3'd0 : y_q + 3'd1;
        end
    end
endmodule

// File: rtl/intra_stage_sched.sv
// intra_stage_sched: per-TU sequencer emitting prefetch stages then the X/Y block scan
module intra_stage_sched
    import intra_sched_pkg::*;
(
    input  logic                 clk,
    input  logic                 arst,
    input  logic                 bStop,
    intra_stage_sched_if.slave   bus
);
    state_t     state_q, state_d;
    logic [1:0] k_q, k_d;
    logic [2:0] tuSize_q;
    logic [5:0] mode_q;
    logic [2:0] p_cur, x_w, y_w;
    logic       accept, legal, consume, clr, en, last;

    intra_blk_scan u_scan (
        .clk   (clk),
        .arst  (arst),
        .clr   (clr),
        .en    (en),
        .n_log (2'(tuSize_q - MIN_TU_LOG2)),
        .x     (x_w),
        .y     (y_w),
        .last  (last)
    );

    // Handshake, next-state and stage outputs; nothing advances while bStop is high
    always_comb begin
        state_d         = state_q;
        k_d             = k_q;
        clr             = 1'b0;
        en              = 1'b0;
        p_cur           = pre_count(tuSize_q, mode_q);
        bus.tu_ready    = (state_q == S_IDLE) && !bStop;
        accept          = bus.tu_valid && bus.tu_ready;
        legal           = (bus.tu_size >= MIN_TU_LOG2) && (bus.tu_size <= MAX_TU_LOG2);
        consume         = (state_q != S_IDLE) && !bStop;
        if (state_q == S_IDLE && accept && legal) begin
            state_d = (pre_count(bus.tu_size, bus.tu_mode) != 3'd0) ? S_PRE : S_MAIN;
            k_d     = 2'd0;
            clr     = 1'b1;
        end
        if (state_q == S_PRE && consume) begin
            k_d     = k_q + 2'd1;
            state_d = ({1'b0, k_q} == p_cur - 3'd1) ? S_MAIN : S_PRE;
        end
        if (state_q == S_MAIN && consume) begin
            en      = 1'b1;
            state_d = last ? S_IDLE : S_MAIN;
        end
        bus.stage_valid = (state_q != S_IDLE);
        bus.preStage    = (state_q == S_IDLE) ? PRE_IDLE :
                          (state_q == S_PRE)  ? {2'b00, k_q} : PRE_MAIN;
        bus.tu_done     = (state_q == S_MAIN) && consume && last;
        bus.cfg_err     = accept && !legal;
        bus.X           = x_w;
        bus.Y           = y_w;
        bus.tuSize      = tuSize_q;
        bus.mode        = mode_q;
    end

    // State, prefetch index and latched TU command
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q  <= S_IDLE;
            k_q      <= '0;
            tuSize_q <= '0;
            mode_q   <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            if (accept) begin
                tuSize_q <= bus.tu_size;
                mode_q   <= bus.tu_mode;
            end
        end
    end
endmodule

// File: tb/tb_intra_stage_sched.sv
// tb_intra_stage_sched: directed self-checking bench for the intra stage scheduler
module tb_intra_stage_sched;
    logic clk = 1'b0;
    logic arst = 1'b1;
    logic bStop = 1'b0;
    int   n_assert = 0;
    int   n_fail = 0;
    int   sv_cnt = 0;
    int   done_cnt = 0;
    int   sv0, dn0, c0;

    intra_stage_sched_if bus ();

    intra_stage_sched dut (
        .clk   (clk),
        .arst  (arst),
        .bStop (bStop),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Independent tallies of presented stages and done pulses
    always @(negedge clk) begin
        if (bus.stage_valid) sv_cnt++;
        if (bus.tu_done) done_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [2:0] size, input logic [5:0] m);
        bus.tu_valid = 1'b1;
        bus.tu_size  = size;
        bus.tu_mode  = m;
        @(negedge clk);
        chk("accept_ready", 32'(bus.tu_ready), 1);
        @(posedge clk);
        #1;
        bus.tu_valid = 1'b0;
    endtask

    task automatic stage(input logic [3:0] pre, input logic [2:0] x, input logic [2:0] y, input logic done);
        @(negedge clk);
        chk("stage_valid", 32'(bus.stage_valid), 1);
        chk("preStage", 32'(bus.preStage), 32'(pre));
        chk("X", 32'(bus.X), 32'(x));
        chk("Y", 32'(bus.Y), 32'(y));
        chk("tu_done", 32'(bus.tu_done), 32'(done));
        chk("busy_ready", 32'(bus.tu_ready), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic stall(input logic [3:0] pre, input logic [2:0] x, input logic [2:0] y, input int n);
        bStop = 1'b1;
        repeat (n) begin
            @(negedge clk);
            chk("stall_valid", 32'(bus.stage_valid), 1);
            chk("stall_pre", 32'(bus.preStage), 32'(pre));
            chk("stall_X", 32'(bus.X), 32'(x));
            chk("stall_Y", 32'(bus.Y), 32'(y));
            chk("stall_done", 32'(bus.tu_done), 0);
            @(posedge clk);
            #1;
        end
        bStop = 1'b0;
    endtask

    task automatic idle_chk();
        @(negedge clk);
        chk("idle_ready", 32'(bus.tu_ready), 1);
        chk("idle_valid", 32'(bus.stage_valid), 0);
        chk("idle_pre", 32'(bus.preStage), 15);
        chk("idle_done", 32'(bus.tu_done), 0);
    endtask

    initial begin
        bus.tu_valid = 1'b0;
        bus.tu_size  = 3'd0;
        bus.tu_mode  = 6'd0;
        // Reset state
        #2;
        chk("rst_ready", 32'(bus.tu_ready), 1);
        chk("rst_valid", 32'(bus.stage_valid), 0);
        chk("rst_pre", 32'(bus.preStage), 15);
        chk("rst_X", 32'(bus.X), 0);
        chk("rst_Y", 32'(bus.Y), 0);
        chk("rst_size", 32'(bus.tuSize), 0);
        chk("rst_mode", 32'(bus.mode), 0);
        chk("rst_done", 32'(bus.tu_done), 0);
        chk("rst_err", 32'(bus.cfg_err), 0);
        @(posedge clk);
        #1;
        arst = 1'b0;
        // bStop blocks acceptance in idle
        bStop = 1'b1;
        bus.tu_valid = 1'b1;
        bus.tu_size  = 3'd3;
        @(negedge clk);
        chk("stop_ready", 32'(bus.tu_ready), 0);
        @(posedge clk);
        #1;
        bus.tu_valid = 1'b0;
        bStop = 1'b0;
        @(negedge clk);
        chk("stop_noaccept", 32'(bus.stage_valid), 0);
        @(posedge clk);
        #1;
        // Size 3, angular: one prefetch then 2x2 scan; a held command while busy is ignored
        send(3'd3, 6'd26);
        bus.tu_valid = 1'b1;
        bus.tu_size  = 3'd5;
        stage(4'd0, 3'd0, 3'd0, 1'b0);
        chk("lat_size", 32'(bus.tuSize), 3);
        chk("lat_mode", 32'(bus.mode), 26);
        stage(4'd8, 3'd0, 3'd0, 1'b0);
        stage(4'd8, 3'd1, 3'd0, 1'b0);
        stage(4'd8, 3'd0, 3'd1, 1'b0);
        bus.tu_valid = 1'b0;
        stage(4'd8, 3'd1, 3'd1, 1'b1);
        idle_chk();
        chk("t1_size_kept", 32'(bus.tuSize), 3);
        @(posedge clk);
        #1;
        // Size 5, mode 0: four prefetches then 8x8 scan
        send(3'd5, 6'd0);
        sv0 = sv_cnt;
        dn0 = done_cnt;
        for (int k = 0; k < 4; k++) stage(4'(k), 3'd0, 3'd0, 1'b0);
        for (int y = 0; y < 8; y++)
            for (int x = 0; x < 8; x++)
                stage(4'd8, 3'(x), 3'(y), (x == 7 && y == 7));
        chk("t2_stage_count", 32'(sv_cnt - sv0), 68);
        chk("t2_done_count", 32'(done_cnt - dn0), 1);
        idle_chk();
        @(posedge clk);
        #1;
        // DC size 2: single stage with immediate done
        send(3'd2, 6'd1);
        stage(4'd8, 3'd0, 3'd0, 1'b1);
        // DC size 4 back-to-back after the one-cycle gap: 4x4 scan, no prefetch
        send(3'd4, 6'd1);
        for (int y = 0; y < 4; y++)
            for (int x = 0; x < 4; x++)
                stage(4'd8, 3'(x), 3'(y), (x == 3 && y == 3));
        idle_chk();
        @(posedge clk);
        #1;
        // Size 5 with stalls at preStage 2 and at the final scan block
        send(3'd5, 6'd10);
        sv0 = sv_cnt;
        dn0 = done_cnt;
        stage(4'd0, 3'd0, 3'd0, 1'b0);
        stage(4'd1, 3'd0, 3'd0, 1'b0);
        stall(4'd2, 3'd0, 3'd0, 3);
        stage(4'd2, 3'd0, 3'd0, 1'b0);
        stage(4'd3, 3'd0, 3'd0, 1'b0);
        for (int y = 0; y < 8; y++)
            for (int x = 0; x < 8; x++) begin
                if (x == 7 && y == 7) stall(4'd8, 3'd7, 3'd7, 2);
                stage(4'd8, 3'(x), 3'(y), (x == 7 && y == 7));
            end
        chk("t4_stage_count", 32'(sv_cnt - sv0), 73);
        chk("t4_done_count", 32'(done_cnt - dn0), 1);
        idle_chk();
        @(posedge clk);
        #1;
        // Illegal sizes: cfg_err pulse, stay idle
        bus.tu_valid = 1'b1;
        bus.tu_size  = 3'd6;
        bus.tu_mode  = 6'd26;
        @(negedge clk);
        chk("err6_pulse", 32'(bus.cfg_err), 1);
        @(posedge clk);
        #1;
        bus.tu_valid = 1'b0;
        idle_chk();
        chk("err6_clear", 32'(bus.cfg_err), 0);
        chk("err6_size", 32'(bus.tuSize), 6);
        @(posedge clk);
        #1;
        bus.tu_valid = 1'b1;
        bus.tu_size  = 3'd1;
        @(negedge clk);
        chk("err1_pulse", 32'(bus.cfg_err), 1);
        @(posedge clk);
        #1;
        bus.tu_valid = 1'b0;
        idle_chk();
        chk("err1_clear", 32'(bus.cfg_err), 0);
        @(posedge clk);
        #1;
        // Legal size never flags cfg_err
        bus.tu_valid = 1'b1;
        bus.tu_size  = 3'd4;
        bus.tu_mode  = 6'd0;
        @(negedge clk);
        chk("legal_noerr", 32'(bus.cfg_err), 0);
        @(posedge clk);
        #1;
        bus.tu_valid = 1'b0;
        // Size 4 mode 0 (accepted above): abort with arst at X=3,Y=2
        dn0 = done_cnt;
        stage(4'd0, 3'd0, 3'd0, 1'b0);
        for (int y = 0; y < 3; y++)
            for (int x = 0; x < 4; x++)
                if (!(x == 3 && y == 2)) stage(4'd8, 3'(x), 3'(y), 1'b0);
        @(negedge clk);
        chk("pre_abort_X", 32'(bus.X), 3);
        chk("pre_abort_Y", 32'(bus.Y), 2);
        #1;
        arst = 1'b1;
        #1;
        chk("abort_valid", 32'(bus.stage_valid), 0);
        chk("abort_pre", 32'(bus.preStage), 15);
        chk("abort_done", 32'(bus.tu_done), 0);
        chk("abort_X", 32'(bus.X), 0);
        chk("abort_Y", 32'(bus.Y), 0);
        @(posedge clk);
        #1;
        arst = 1'b0;
        chk("abort_no_done", 32'(done_cnt - dn0), 0);
        // Normal size-3 run after the abort
        send(3'd3, 6'd26);
        stage(4'd0, 3'd0, 3'd0, 1'b0);
        stage(4'd8, 3'd0, 3'd0, 1'b0);
        stage(4'd8, 3'd1, 3'd0, 1'b0);
        stage(4'd8, 3'd0, 3'd1, 1'b0);
        stage(4'd8, 3'd1, 3'd1, 1'b1);
        idle_chk();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        c0 = 0;
        repeat (5000) @(posedge clk);
        $display("FAIL timeout: observed no completion within 5000 cycles");
        $fatal(1, "timeout");
    end
endmodule
